// File: rtl/stream_concat_pkg.sv
// Shared stream types for the concat and splitter blocks.
package stream_concat_pkg;

  // Concat input select: drain stream A first, then stream B.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_state_t;

  localparam int STREAM_WIDTH = 32;

  // One stream beat: payload plus end-of-segment marker.
  typedef struct packed {
    logic [STREAM_WIDTH-1:0] data;
    logic                    last;
  } stream_word_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer / register slice. Ready depends only on local state,
// so there is no combinational path from out_ready to in_ready.
module stream_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;
  logic             drain;

  assign in_ready  = ~skid_valid;
  assign push      = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign out_data  = main_data;
  assign out_valid = main_valid;

  // Main/skid occupancy: refill main from skid first, else from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // in_ready is low while skid is occupied, so no push can coincide here
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= push;
        if (push) main_data <= in_data;
      end
    end else if (push) begin
      if (!main_valid) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_concat.sv
// Concatenates stream A then stream B into one output stream, per matrix.
// Optional feature macro: STREAM_CONCAT_LEN_CHECK_EN enables the sticky
// stream-A length check on len_err; otherwise len_err is tied low.
module stream_concat
  import stream_concat_pkg::*;
#(
  parameter int WIDTH                    = 32,
  parameter int NUM_ELEMENTS_FIRST_INPUT = 55
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ds_in_a_next_data,
  input  logic [WIDTH-1:0] ds_in_a,
  input  logic             ds_in_a_valid,
  input  logic             ds_in_a_last,
  output logic             ds_in_b_next_data,
  input  logic [WIDTH-1:0] ds_in_b,
  input  logic             ds_in_b_valid,
  input  logic             ds_in_b_last,
  input  logic             ds_out_next_data,
  output logic [WIDTH-1:0] ds_out,
  output logic             ds_out_valid,
  output logic             ds_out_last,
  output logic             len_err
);

  if (NUM_ELEMENTS_FIRST_INPUT < 1) begin : g_bad_len
    $error("stream_concat: NUM_ELEMENTS_FIRST_INPUT must be at least 1");
  end

  sel_state_t     state;
  sel_state_t     state_nxt;
  logic           buf_ready;
  logic           sel_valid;
  logic [WIDTH:0] sel_word;
  logic           a_xfer;
  logic           b_xfer;

  assign ds_in_a_next_data = (state == SEL_A) & buf_ready;
  assign ds_in_b_next_data = (state == SEL_B) & buf_ready;
  assign a_xfer            = ds_in_a_valid & ds_in_a_next_data;
  assign b_xfer            = ds_in_b_valid & ds_in_b_next_data;

  // A's last only steers the FSM; B's last marks the end of the merged matrix.
  assign sel_valid = (state == SEL_A) ? ds_in_a_valid : ds_in_b_valid;
  assign sel_word  = (state == SEL_A) ? {ds_in_a, 1'b0} : {ds_in_b, ds_in_b_last};

  // Select state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEL_A;
    else     state <= state_nxt;
  end

  // Switch segments on the transfer that carries the segment's last flag.
  always_comb begin
    state_nxt = state;
    case (state)
      SEL_A:   if (a_xfer && ds_in_a_last) state_nxt = SEL_B;
      SEL_B:   if (b_xfer && ds_in_b_last) state_nxt = SEL_A;
      default: state_nxt = SEL_A;
    endcase
  end

  stream_skid_buffer #(
    .WIDTH (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (sel_word),
    .in_valid  (sel_valid),
    .in_ready  (buf_ready),
    .out_data  ({ds_out, ds_out_last}),
    .out_valid (ds_out_valid),
    .out_ready (ds_out_next_data)
  );

`ifdef STREAM_CONCAT_LEN_CHECK_EN
  localparam int CNT_W = $clog2(NUM_ELEMENTS_FIRST_INPUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_ELEMENTS_FIRST_INPUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEMENTS_FIRST_INPUT - 1);

  logic [CNT_W-1:0] a_cnt;
  logic             err_q;

  assign len_err = err_q;

  // Count A words per matrix (saturating) and latch any length mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= '0;
      err_q <= 1'b0;
    end else if (a_xfer) begin
      if (ds_in_a_last) begin
        a_cnt <= '0;
        if (a_cnt != CNT_LAST) err_q <= 1'b1;
      end else begin
        if (a_cnt != CNT_MAX)  a_cnt <= a_cnt + 1'b1;
        if (a_cnt == CNT_LAST) err_q <= 1'b1;
      end
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_concat.sv
// Self-checking bench for stream_concat (NUM_ELEMENTS_FIRST_INPUT = 4).
module tb_stream_concat;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_ready, b_ready;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         a_valid = 1'b0, a_last = 1'b0;
  logic         b_valid = 1'b0, b_last = 1'b0;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_data;
  logic         o_valid, o_last, len_err;

  stream_concat #(.WIDTH(W), .NUM_ELEMENTS_FIRST_INPUT(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .ds_in_a_next_data (a_ready),
    .ds_in_a           (a_data),
    .ds_in_a_valid     (a_valid),
    .ds_in_a_last      (a_last),
    .ds_in_b_next_data (b_ready),
    .ds_in_b           (b_data),
    .ds_in_b_valid     (b_valid),
    .ds_in_b_last      (b_last),
    .ds_out_next_data  (o_ready),
    .ds_out            (o_data),
    .ds_out_valid      (o_valid),
    .ds_out_last       (o_last),
    .len_err           (len_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Source queues ({data,last}) and the reference: expected output words.
  logic [W:0] a_q[$], b_q[$], exp_q[$];
  int  last_pos[$];
  bit  hold = 1'b1;
  int  rdy_pct = 100, gap_pct = 0;
  bit  rdy_force_en = 1'b0, rdy_force = 1'b0;
  bit  a_fire, b_fire, o_fire;
  bit  phase_a = 1'b1;
  int  in_flight = 0;
  bit  prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  int  cyc = 0;
  int  out_cnt, a_acc, b_acc, first_a_cyc, first_out_cyc, last_out_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_stats();
    out_cnt = 0; a_acc = 0; b_acc = 0;
    first_a_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    last_pos.delete();
  endtask

  // Matrix model: the output is every A word (last cleared) followed by every B word.
  task automatic enqueue_matrix(input int na, input int nb, input int base);
    for (int i = 0; i < na; i++) begin
      a_q.push_back({W'(base + i), i == na - 1});
      exp_q.push_back({W'(base + i), 1'b0});
    end
    for (int i = 0; i < nb; i++) begin
      b_q.push_back({W'(base + na + i), i == nb - 1});
      exp_q.push_back({W'(base + na + i), i == nb - 1});
    end
  endtask

  // Driver: retire accepted words, then present the next ones.
  initial begin
    logic [W:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (a_fire && a_q.size() > 0) void'(a_q.pop_front());
      if (b_fire && b_q.size() > 0) void'(b_q.pop_front());
      if (hold || rst) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end else begin
        a_valid = a_q.size() > 0 && $urandom_range(99) >= gap_pct;
        w = (a_q.size() > 0) ? a_q[0] : '0;
        a_data = w[W:1]; a_last = w[0];
        b_valid = b_q.size() > 0 && $urandom_range(99) >= gap_pct;
        w = (b_q.size() > 0) ? b_q[0] : '0;
        b_data = w[W:1]; b_last = w[0];
      end
      o_ready = rdy_force_en ? rdy_force : ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: protocol rules and in-order comparison against the reference queue.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      a_fire = 0; b_fire = 0; o_fire = 0; prev_stall = 0;
    end else begin
      a_fire = a_valid & a_ready;
      b_fire = b_valid & b_ready;
      o_fire = o_valid & o_ready;
      check(phase_a ? "b_ready_in_a" : "a_ready_in_b", phase_a ? b_ready : a_ready, 0);
      check("out_valid_occ", o_valid, in_flight != 0);
      if (in_flight == 2) check("full_readies", a_ready | b_ready, 0);
      if (prev_stall) check("stall_hold", o_data, prev_data);
      if (o_fire) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_data", o_data, e[W:1]);
          check("out_last", o_last, e[0]);
        end
        out_cnt++;
        if (o_last) last_pos.push_back(out_cnt);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (a_fire) begin
        a_acc++;
        if (first_a_cyc < 0) first_a_cyc = cyc;
        if (a_last) phase_a = 0;
      end
      if (b_fire) begin
        b_acc++;
        if (b_last) phase_a = 1;
      end
      in_flight = in_flight + ((a_fire | b_fire) ? 1 : 0) - (o_fire ? 1 : 0);
      prev_stall = o_valid & ~o_ready;
      prev_data  = o_data;
    end
  end

  task automatic wait_done(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (a_q.size() == 0 && b_q.size() == 0 && exp_q.size() == 0 && in_flight == 0) done = 1;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    hold = 1; rst = 1;
    a_valid = 0; b_valid = 0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    phase_a = 1; in_flight = 0; prev_stall = 0;
    a_fire = 0; b_fire = 0; o_fire = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    clear_stats();
  endtask

  typedef struct {
    int na; int nb; int rdy; int gap;
    int exp_words; int exp_lasts; logic exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int total;
    tbl[0] = '{4, 1, 100,  0,  5, 1, 1'b0};
    tbl[1] = '{4, 3,  50, 30,  7, 1, 1'b0};
    tbl[2] = '{4, 6,  70,  0, 10, 1, 1'b0};
    tbl[3] = '{4, 2,  30, 50,  6, 1, 1'b0};
    tbl[4] = '{4, 5, 100, 60,  9, 1, 1'b0};
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", o_valid, 0);
    check("rst_out_last", o_last, 0);
    check("rst_out_data", o_data, 0);
    check("rst_len_err", len_err, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 0);
    rst = 0;

    // Basic merge: latency 1, no bubbles
    clear_stats();
    enqueue_matrix(4, 3, 1);
    hold = 0;
    wait_done(200);
    check("basic_latency", first_out_cyc - first_a_cyc, 1);
    check("basic_no_bubble", last_out_cyc - first_out_cyc, 6);
    check("basic_count", out_cnt, 7);
    check("basic_last_pos", (last_pos.size() == 1) ? last_pos[0] : -1, 7);

    // Ordering: B presented while A idle must not be accepted
    hold = 1; clear_stats();
    b_q.push_back({W'(5), 1'b0});
    b_q.push_back({W'(6), 1'b1});
    hold = 0;
    repeat (6) @(negedge clk);
    check("order_b_blocked", b_acc, 0);
    for (int i = 0; i < 4; i++) begin
      a_q.push_back({W'(1 + i), i == 3});
      exp_q.push_back({W'(1 + i), 1'b0});
    end
    exp_q.push_back({W'(5), 1'b0});
    exp_q.push_back({W'(6), 1'b1});
    wait_done(200);
    check("order_count", out_cnt, 6);

    // Backpressure mid-A
    hold = 1; clear_stats();
    enqueue_matrix(4, 3, 1);
    hold = 0;
    for (int i = 0; i < 100 && a_acc < 2; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rdy_force_en = 1; rdy_force = 0; o_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("bp_readies_low", a_ready | b_ready, 0);
    check("bp_in_flight", in_flight, 2);
    rdy_force_en = 0;
    wait_done(200);
    check("bp_count", out_cnt, 7);

    // Back-to-back matrices
    hold = 1; clear_stats();
    enqueue_matrix(4, 2, 1);
    enqueue_matrix(4, 2, 7);
    hold = 0;
    wait_done(300);
    check("b2b_count", out_cnt, 12);
    check("b2b_last1", (last_pos.size() == 2) ? last_pos[0] : -1, 6);
    check("b2b_last2", (last_pos.size() == 2) ? last_pos[1] : -1, 12);

    // Reset mid-stream
    hold = 1; clear_stats();
    enqueue_matrix(4, 3, 100);
    hold = 0;
    for (int i = 0; i < 100 && a_acc < 2; i++) begin
      @(posedge clk);
      #2;
    end
    rst = 1; hold = 1; a_valid = 0; b_valid = 0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_last", o_last, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_len_err", len_err, 0);
    a_q.delete(); b_q.delete(); exp_q.delete();
    phase_a = 1; in_flight = 0; prev_stall = 0;
    a_fire = 0; b_fire = 0; o_fire = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    clear_stats();
    enqueue_matrix(4, 3, 200);
    hold = 0;
    wait_done(200);
    check("post_rst_count", out_cnt, 7);

    // Table-driven matrices with varied backpressure and source gaps
    foreach (tbl[k]) begin
      hold = 1; clear_stats();
      rdy_pct = tbl[k].rdy; gap_pct = tbl[k].gap;
      enqueue_matrix(tbl[k].na, tbl[k].nb, 1000 * (k + 1));
      hold = 0;
      wait_done(500);
      check("tbl_words", out_cnt, tbl[k].exp_words);
      check("tbl_lasts", last_pos.size(), tbl[k].exp_lasts);
      check("tbl_len_err", len_err, tbl[k].exp_err);
    end

    // Randomized matrices queued back to back
    hold = 1; clear_stats(); total = 0;
    rdy_pct = 60; gap_pct = 25;
    for (int m = 0; m < 15; m++) begin
      int na, nb;
      na = $urandom_range(7, 1);
      nb = $urandom_range(5, 1);
      enqueue_matrix(na, nb, $urandom_range(32'h00ff_ffff));
      total += na + nb;
    end
    hold = 0;
    wait_done(3000);
    check("rand_words", out_cnt, total);
    check("rand_lasts", last_pos.size(), 15);
    rdy_pct = 100; gap_pct = 0;

    // Length check
    do_reset();
    enqueue_matrix(3, 1, 50);
    hold = 0;
    wait_done(200);
    check("len3_count", out_cnt, 4);
`ifdef STREAM_CONCAT_LEN_CHECK_EN
    check("len3_err", len_err, 1);
    hold = 1;
    enqueue_matrix(4, 1, 60);
    hold = 0;
    wait_done(200);
    check("len_err_sticky", len_err, 1);
    do_reset();
    check("len_err_cleared", len_err, 0);
    enqueue_matrix(4, 2, 70);
    hold = 0;
    wait_done(200);
    check("len4_err", len_err, 0);
`else
    check("len3_err_off", len_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/stream_concat.md
Name: stream_concat

Overview:
- Merges two data streams into one output stream, in sequence: all of stream A, then all of stream B, then repeat.
- Sits downstream of the stream splitter. It rejoins the leading segment (after its own processing path) with the tail segment into a single matrix stream.
- Output is registered through a 2-entry skid buffer, so no combinational path exists from ds_out_next_data to either input ready.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_ELEMENTS_FIRST_INPUT, 55, expected element count of stream A per matrix; used only by the length check.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- ds_in_a_next_data  output  1  block ready to accept a word from A.
- ds_in_a  input  WIDTH  stream A data.
- ds_in_a_valid  input  1  ds_in_a is valid.
- ds_in_a_last  input  1  final element of A's segment.
- ds_in_b_next_data  output  1  block ready to accept a word from B.
- ds_in_b  input  WIDTH  stream B data.
- ds_in_b_valid  input  1  ds_in_b is valid.
- ds_in_b_last  input  1  final element of the matrix.
- ds_out_next_data  input  1  downstream ready.
- ds_out  output  WIDTH  merged data.
- ds_out_valid  output  1  ds_out is valid.
- ds_out_last  output  1  final element of the merged matrix.
- len_err  output  1  sticky stream-A length mismatch flag.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State goes to SEL_A; A-element counter to 0; both skid entries invalid.
  - ds_out_valid = 0, ds_out_last = 0, ds_out = 0, len_err = 0.
  - Reset mid-transfer discards all buffered words.
- Handshake: a transfer occurs on a port when valid and next_data are both high at a rising edge.
- Ready rules:
  - Ready = NOT skid_full, gated by state.
  - In SEL_A: ds_in_a_next_data = NOT skid_full; ds_in_b_next_data = 0.
  - In SEL_B: the mirror of SEL_A.
- FSM:
  - SEL_A -> SEL_B on an A transfer with ds_in_a_last = 1.
  - SEL_B -> SEL_A on a B transfer with ds_in_b_last = 1.
  - No other transitions.
- Last flag:
  - A's last flag is consumed and never forwarded; words from A are buffered with last = 0.
  - Words from B are buffered with last = ds_in_b_last.
- Skid buffer (main + skid registers, each holding data, last, valid):
  - Accepted word goes to main if main is empty or main drains this cycle; otherwise it goes to skid.
  - When main drains and skid is valid, skid moves to main.
  - ds_out, ds_out_valid and ds_out_last come from main.
  - Latency: 1 cycle from input transfer to ds_out_valid.
  - Sustained throughput: 1 word/cycle when downstream is always ready.
- Backpressure:
  - At most 2 words in flight.
  - When skid is valid, both readies are 0 in the next cycle.
  - No word is lost or duplicated.
  - ds_out holds stable while ds_out_valid = 1 and ds_out_next_data = 0.
- Counter:
  - Width clog2(NUM_ELEMENTS_FIRST_INPUT+1).
  - Increments on every A transfer.
  - Clears on the A transfer that carries last.
  - Saturates at NUM_ELEMENTS_FIRST_INPUT.
- Simultaneous events: A-last transfer and output drain in the same cycle are both honoured; the FSM switches, and B is selectable the very next cycle.
- Empty A segment is not supported: A must deliver at least one word with last.

Optional Feature:
- Macro: STREAM_CONCAT_LEN_CHECK_EN.
- Defined:
  - On an A-last transfer, len_err is set if the counter value (before increment) is not NUM_ELEMENTS_FIRST_INPUT-1.
  - len_err is also set on an A transfer without last when the counter is already NUM_ELEMENTS_FIRST_INPUT-1.
  - Sticky until rst.
  - Data flow is unaffected.
- Undefined:
  - len_err is tied to 0.
  - Counter logic is not generated.

Decomposition:
- Shared stream package:
  - typedef enum for the concat select state {SEL_A, SEL_B}.
  - Packed struct stream_word_t {data[WIDTH-1:0], last}, reused by splitter-side logic.
- Sub-module stream_skid_buffer (WIDTH+1 payload, 2 entries), instantiated once. It is reusable as a generic register slice.

Test Plan (NUM_ELEMENTS_FIRST_INPUT = 4 unless stated):
- Basic merge: A = 1,2,3,4 (last on 4), B = 5,6,7 (last on 7), downstream always ready -> out 1..7 with last only on 7; first valid 1 cycle after first A transfer; no bubbles.
- Ordering: B valid from cycle 0 with 5,6 while A idle -> ds_in_b_next_data = 0 until A word 4 transfers; output order is A before B.
- Backpressure: ds_out_next_data low for 3 cycles mid-A -> at most 2 words buffered, readies drop to 0, ds_out stable; on release the sequence 1..7 completes intact.
- Back-to-back matrices: two matrices of A = 4 and B = 2 words sent continuously -> 12 words out, last on words 6 and 12, FSM returns to SEL_A after word 6.
- Reset mid-stream: assert rst after 2 A words are accepted -> all outputs 0 immediately; a subsequent full matrix is produced correctly.
- Length check (macro defined): A = 3 words with last on the 3rd -> len_err = 1 the cycle after that transfer, stays 1, data still forwarded; A = 4 words -> len_err = 0.
